// File: rtl/sdram_arbiter_pkg.sv
// Shared types and defaults for the SDRAM arbiter and its refresh tracker.
package sdram_arbiter_pkg;

  localparam int ADDR_W   = 26;
  localparam int DS_W     = 4;
  localparam int DEBT_W   = 4;
  localparam int STARVE_W = 3;

  localparam int MAX_DEBT_DEF     = 8;
  localparam int URGENT_DEBT_DEF  = 6;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE    = 2'd0,
    SRC_Z3      = 2'd1,
    SRC_DMA     = 2'd2,
    SRC_REFRESH = 2'd3
  } src_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Request ports, sequencer command bus and status of the SDRAM arbiter.
interface sdram_arbiter_if;
  import sdram_arbiter_pkg::*;

  logic              init_done;
  logic              z3_req;
  logic [ADDR_W-1:0] z3_addr;
  logic              z3_rw;
  logic [DS_W-1:0]   z3_ds_n;
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_rw;
  logic [DS_W-1:0]   dma_ds_n;
  logic              seq_done;
  logic              seq_start;
  logic              seq_refresh;
  logic [ADDR_W-1:0] seq_addr;
  logic              seq_rw;
  logic [DS_W-1:0]   seq_ds_n;
  logic              z3_gnt;
  logic              dma_gnt;
  logic [DEBT_W-1:0] refresh_debt;
  logic              refresh_overrun;

  modport master (
    input  init_done, z3_req, z3_addr, z3_rw, z3_ds_n,
           dma_req, dma_addr, dma_rw, dma_ds_n, seq_done,
    output seq_start, seq_refresh, seq_addr, seq_rw, seq_ds_n,
           z3_gnt, dma_gnt, refresh_debt, refresh_overrun
  );

  modport slave (
    output init_done, z3_req, z3_addr, z3_rw, z3_ds_n,
           dma_req, dma_addr, dma_rw, dma_ds_n, seq_done,
    input  seq_start, seq_refresh, seq_addr, seq_rw, seq_ds_n,
           z3_gnt, dma_gnt, refresh_debt, refresh_overrun
  );

endinterface

// File: rtl/sdram_refresh_tracker.sv
// Counts refresh debt from synchronised ECLK rising edges; refresh completions pay it back.
module sdram_refresh_tracker
  import sdram_arbiter_pkg::*;
#(
  parameter int MAX_DEBT = MAX_DEBT_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ECLK,
  input  logic              init_done,
  input  logic              refresh_done,
  output logic [DEBT_W-1:0] debt,
  output logic              overrun
);

  localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_DEBT);

  logic eclk_s1, eclk_s2, eclk_d;
  logic inc;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      eclk_s1 <= 1'b0;
      eclk_s2 <= 1'b0;
      eclk_d  <= 1'b0;
    end else begin
      eclk_s1 <= ECLK;
      eclk_s2 <= eclk_s1;
      eclk_d  <= eclk_s2;
    end
  end

  assign inc = eclk_s2 & ~eclk_d & init_done;

  // A tick and a refresh completion in the same cycle cancel out.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      debt    <= '0;
      overrun <= 1'b0;
    end else if (inc && !refresh_done) begin
      if (debt == DEBT_MAX) overrun <= 1'b1;
      else                  debt    <= debt + 1'b1;
    end else if (refresh_done && !inc && debt != '0) begin
      debt <= debt - 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM sequencer between Z3 host, DMA and refresh; one operation in flight.
//   state | meaning
//   IDLE  | pick a winner, latch its command
//   ISSUE | pulse seq_start
//   BUSY  | hold command and grant until seq_done
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int MAX_DEBT     = MAX_DEBT_DEF,
  parameter int URGENT_DEBT  = URGENT_DEBT_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            ECLK,
  sdram_arbiter_if.master bus
);

  localparam logic [DEBT_W-1:0]   DEBT_URGENT = DEBT_W'(URGENT_DEBT);
  localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  src_e                src_q, win;
  logic [STARVE_W-1:0] starve_q;
  logic [ADDR_W-1:0]   seq_addr_q;
  logic                seq_rw_q;
  logic [DS_W-1:0]     seq_ds_n_q;
  logic [DEBT_W-1:0]   debt;
  logic                overrun;
  logic                refresh_done;

  assign refresh_done = (state_q == BUSY) && bus.seq_done && (src_q == SRC_REFRESH);

  sdram_refresh_tracker #(.MAX_DEBT(MAX_DEBT)) u_refresh (
    .CLK          (CLK),
    .RESET        (RESET),
    .ECLK         (ECLK),
    .init_done    (bus.init_done),
    .refresh_done (refresh_done),
    .debt         (debt),
    .overrun      (overrun)
  );

  always_comb begin
    win = SRC_NONE;
    if (bus.init_done) begin
      if (debt >= DEBT_URGENT)                         win = SRC_REFRESH;
      else if (bus.dma_req && starve_q == STARVE_MAX) win = SRC_DMA;
      else if (bus.z3_req)                             win = SRC_Z3;
      else if (bus.dma_req)                            win = SRC_DMA;
      else if (debt != '0)                             win = SRC_REFRESH;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win != SRC_NONE) state_d = ISSUE;
      ISSUE:   state_d = BUSY;
      BUSY:    if (bus.seq_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.seq_start   = (state_q == ISSUE);
    bus.z3_gnt      = (src_q == SRC_Z3);
    bus.dma_gnt     = (src_q == SRC_DMA);
    bus.seq_refresh = (src_q == SRC_REFRESH);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      src_q      <= SRC_NONE;
      seq_addr_q <= '0;
      seq_rw_q   <= 1'b0;
      seq_ds_n_q <= '1;
      starve_q   <= '0;
    end else if (state_q == IDLE) begin
      src_q <= win;
      case (win)
        SRC_Z3: begin
          seq_addr_q <= bus.z3_addr;
          seq_rw_q   <= bus.z3_rw;
          seq_ds_n_q <= bus.z3_ds_n;
        end
        SRC_DMA: begin
          seq_addr_q <= bus.dma_addr;
          seq_rw_q   <= bus.dma_rw;
          seq_ds_n_q <= bus.dma_ds_n;
        end
        default: ;
      endcase
      // Refresh grants leave the starvation count alone.
      if (win == SRC_DMA || !bus.dma_req)          starve_q <= '0;
      else if (win == SRC_Z3 && starve_q != STARVE_MAX) starve_q <= starve_q + 1'b1;
    end else if (state_q == BUSY && bus.seq_done) begin
      src_q <= SRC_NONE;
    end
  end

  assign bus.seq_addr        = seq_addr_q;
  assign bus.seq_rw          = seq_rw_q;
  assign bus.seq_ds_n        = seq_ds_n_q;
  assign bus.refresh_debt    = debt;
  assign bus.refresh_overrun = overrun;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small behavioural sequencer.
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  logic ECLK  = 1'b0;

  sdram_arbiter_if bus();

  sdram_arbiter dut (
    .CLK   (CLK),
    .RESET (RESET),
    .ECLK  (ECLK),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic seq_done_auto = 1'b0;
  logic seq_done_man  = 1'b0;
  bit   auto_seq  = 1'b0;
  bit   hold_done = 1'b0;
  int   seq_lat   = 2;
  int   start_cnt = 0;
  int   guard;
  int   n_ref;
  int   first_ref;
  logic [1:0] log_src[$];
  logic [3:0] log_debt[$];
  logic [1:0] exp_arb [0:10];

  localparam logic [31:0] RST_OUTS = {18'd0, 5'b00000, 4'b1111, 1'b0, 4'd0};

  assign bus.seq_done = seq_done_auto | seq_done_man;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {18'd0, bus.seq_start, bus.seq_refresh, bus.z3_gnt, bus.dma_gnt, bus.seq_rw,
            bus.seq_ds_n, bus.refresh_overrun, bus.refresh_debt};
  endfunction

  function automatic logic [1:0] grant_code();
    if (bus.z3_gnt)      return 2'd1;
    if (bus.dma_gnt)     return 2'd2;
    if (bus.seq_refresh) return 2'd3;
    return 2'd0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic tick();
    ECLK = 1'b1;
    cyc(4);
    ECLK = 1'b0;
    cyc(4);
  endtask

  task automatic wait_idle(input int limit);
    guard = 0;
    while ((bus.refresh_debt != 0 || bus.z3_gnt || bus.dma_gnt || bus.seq_refresh) && guard < limit) begin
      cyc(1);
      guard++;
    end
  endtask

  // Sequencer model: logs each seq_start and, in auto mode, answers with seq_done.
  initial begin : seq_model
    bit active;
    int cnt;
    active = 1'b0;
    cnt    = 0;
    forever begin
      @(posedge CLK);
      #1;
      seq_done_auto = 1'b0;
      if (RESET) begin
        active = 1'b0;
      end else if (bus.seq_start) begin
        start_cnt++;
        log_src.push_back(grant_code());
        log_debt.push_back(bus.refresh_debt);
        if (auto_seq) begin
          active = 1'b1;
          cnt    = seq_lat;
        end
      end else if (active) begin
        if (cnt > 0) cnt--;
        if (cnt == 0 && !hold_done) begin
          seq_done_auto = 1'b1;
          active        = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.init_done = 1'b0;
    bus.z3_req    = 1'b0;
    bus.z3_addr   = '0;
    bus.z3_rw     = 1'b0;
    bus.z3_ds_n   = 4'hF;
    bus.dma_req   = 1'b0;
    bus.dma_addr  = 26'h2ABCDEF;
    bus.dma_rw    = 1'b1;
    bus.dma_ds_n  = 4'h0;

    // Reset and pre-init behaviour
    cyc(3);
    chk("reset_outs", outs(), RST_OUTS);
    chk("reset_addr", 32'(bus.seq_addr), 32'd0);
    repeat (10) tick();
    chk("debt_in_reset", 32'(bus.refresh_debt), 32'd0);
    RESET = 1'b0;
    repeat (10) tick();
    chk("debt_no_init", 32'(bus.refresh_debt), 32'd0);
    chk("no_start_no_init", 32'(start_cnt), 32'd0);
    bus.init_done = 1'b1;
    cyc(10);
    chk("no_grant_before_tick", 32'(start_cnt), 32'd0);

    // First tick gives an idle refresh; manual completion
    tick();
    chk("idle_refresh", {30'd0, bus.seq_refresh, bus.refresh_debt == 4'd1}, 32'd3);
    seq_done_man = 1'b1;
    cyc(1);
    seq_done_man = 1'b0;
    chk("refresh_paid", 32'(bus.refresh_debt), 32'd0);
    chk("refresh_drop", 32'(bus.seq_refresh), 32'd0);

    // Z3 only: exact latency and latched command
    bus.z3_addr = 26'h0123456;
    bus.z3_rw   = 1'b0;
    bus.z3_ds_n = 4'b0011;
    bus.z3_req  = 1'b1;
    cyc(1);
    chk("z3_start", {28'd0, bus.seq_start, bus.z3_gnt, bus.dma_gnt, bus.seq_refresh}, 32'b1100);
    chk("z3_addr", 32'(bus.seq_addr), 32'h0123456);
    chk("z3_rw_ds", {27'd0, bus.seq_rw, bus.seq_ds_n}, 32'b0_0011);
    bus.z3_addr = 26'h3FFFFFF;
    bus.z3_ds_n = 4'hF;
    cyc(3);
    chk("z3_busy_hold", {26'd0, bus.seq_start, bus.z3_gnt, bus.seq_ds_n}, {26'd0, 1'b0, 1'b1, 4'b0011});
    chk("z3_busy_addr", 32'(bus.seq_addr), 32'h0123456);
    seq_done_man = 1'b1;
    bus.z3_req   = 1'b0;
    chk("z3_gnt_done_cycle", 32'(bus.z3_gnt), 32'd1);
    cyc(1);
    seq_done_man = 1'b0;
    chk("z3_gnt_drop", 32'(bus.z3_gnt), 32'd0);
    cyc(4);
    chk("z3_no_regrant", 32'(start_cnt), 32'd2);

    // Z3 vs DMA, both requesting continuously
    auto_seq = 1'b1;
    log_src.delete();
    log_debt.delete();
    exp_arb = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
    bus.z3_req  = 1'b1;
    bus.dma_req = 1'b1;
    guard = 0;
    while (log_src.size() < 11 && guard < 400) begin
      cyc(1);
      guard++;
    end
    bus.z3_req  = 1'b0;
    bus.dma_req = 1'b0;
    cyc(10);
    chk("arb_count", 32'(log_src.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      chk($sformatf("arb_order[%0d]", i), (i < log_src.size()) ? 32'(log_src[i]) : 32'd0, 32'(exp_arb[i]));

    // Refresh deferral behind constant Z3 traffic
    log_src.delete();
    log_debt.delete();
    bus.z3_req = 1'b1;
    repeat (5) tick();
    chk("defer_debt5", 32'(bus.refresh_debt), 32'd5);
    n_ref = 0;
    foreach (log_src[i]) if (log_src[i] == 2'd3) n_ref++;
    chk("defer_no_refresh", 32'(n_ref), 32'd0);
    tick();
    guard     = 0;
    first_ref = -1;
    while (first_ref < 0 && guard < 60) begin
      foreach (log_src[i]) if (log_src[i] == 2'd3 && first_ref < 0) first_ref = i;
      if (first_ref < 0) cyc(1);
      guard++;
    end
    chk("urgent_seen", 32'(first_ref >= 0), 32'd1);
    chk("urgent_at_debt6", (first_ref >= 0) ? 32'(log_debt[first_ref]) : 32'd0, 32'd6);
    guard = 0;
    while (bus.seq_refresh && guard < 60) begin
      cyc(1);
      guard++;
    end
    cyc(1);
    chk("urgent_6to5", 32'(bus.refresh_debt), 32'd5);
    bus.z3_req = 1'b0;
    wait_idle(300);
    chk("drain_zero", 32'(bus.refresh_debt), 32'd0);

    // Saturation while stuck in BUSY
    hold_done  = 1'b1;
    bus.z3_req = 1'b1;
    guard = 0;
    while (!bus.z3_gnt && guard < 20) begin
      cyc(1);
      guard++;
    end
    bus.z3_req = 1'b0;
    repeat (8) tick();
    chk("sat_debt8", {27'd0, bus.refresh_overrun, bus.refresh_debt}, {27'd0, 1'b0, 4'd8});
    tick();
    chk("sat_overrun", {26'd0, bus.z3_gnt, bus.refresh_overrun, bus.refresh_debt}, {26'd0, 1'b1, 1'b1, 4'd8});
    hold_done = 1'b0;
    wait_idle(400);
    chk("overrun_sticky", {27'd0, bus.refresh_overrun, bus.refresh_debt}, {27'd0, 1'b1, 4'd0});

    // Tick coinciding with refresh completion
    auto_seq = 1'b0;
    cyc(5);
    tick();
    chk("sim_setup", {30'd0, bus.seq_refresh, bus.refresh_debt == 4'd1}, 32'd3);
    ECLK = 1'b1;
    cyc(2);
    seq_done_man = 1'b1;
    cyc(1);
    seq_done_man = 1'b0;
    chk("tick_and_done_debt", 32'(bus.refresh_debt), 32'd1);
    chk("tick_and_done_drop", 32'(bus.seq_refresh), 32'd0);
    cyc(3);
    ECLK = 1'b0;

    // Reset while busy on the next refresh
    chk("busy_before_reset", 32'(bus.seq_refresh), 32'd1);
    RESET = 1'b1;
    cyc(1);
    chk("reset_in_busy", outs(), RST_OUTS);
    chk("reset_in_busy_addr", 32'(bus.seq_addr), 32'd0);
    RESET = 1'b0;
    cyc(10);
    chk("post_reset_waits_tick", 32'(bus.seq_start | bus.seq_refresh), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
